pc_gen_unit: RTL and testbench

//  Parametrised program-counter generator for the RISC-V core, successor to the plain PC register.

---
 rtl/pc_gen_unit_if.sv | 35 +++
 rtl/pc_gen_unit.sv | 145 ++++++++++++++
 tb/tb_pc_gen_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_unit_if.sv
// Fetch-side bundle of pc_gen_unit: next-PC control inputs, instruction-memory
// handshake, return-address-stack controls and the resulting status outputs.
// master: the control unit / next-PC logic side; slave: pc_gen_unit itself.
interface pc_gen_unit_if #(
    parameter int N = 32
);
    logic         fetch_ready;
    logic         redirect_valid;
    logic [N-1:0] redirect_target;
    logic         trap_req;
    logic         halt_req;
    logic         resume;
    logic         ras_push;
    logic [N-1:0] ras_push_addr;
    logic         ras_pop;

    logic [N-1:0] PC_Value;
    logic         fetch_valid;
    logic [N-1:0] ras_top;
    logic         ras_empty;
    logic         ras_full;
    logic         misaligned_err;

    modport master (
        output fetch_ready, redirect_valid, redirect_target, trap_req, halt_req,
               resume, ras_push, ras_push_addr, ras_pop,
        input  PC_Value, fetch_valid, ras_top, ras_empty, ras_full, misaligned_err
    );

    modport slave (
        input  fetch_ready, redirect_valid, redirect_target, trap_req, halt_req,
               resume, ras_push, ras_push_addr, ras_pop,
        output PC_Value, fetch_valid, ras_top, ras_empty, ras_full, misaligned_err
    );
endinterface

// File: rtl/pc_gen_unit.sv
// Program-counter generator: fetch PC register with imem stall handshake,
// branch/jump redirect, trap vectoring, halt/resume and a circular
// return-address stack. Optional macro PC_ALIGN_CHECK_EN rejects redirects
// whose target is not word aligned and pulses misaligned_err instead.
module pc_gen_unit #(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = 'h0040_0000,
    parameter logic [N-1:0] TRAP_VECTOR  = 'h0040_0180,
    parameter int           INC          = 4,
    parameter int           RAS_DEPTH    = 4
) (
    input logic         clk,
    input logic         reset,
    pc_gen_unit_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         err_q, err_d;
    logic         redirect_bad;

    // Sequential increment; wraps modulo 2^N with no carry out.
    function automatic logic [N-1:0] pc_inc(input logic [N-1:0] pc);
        return pc + N'(INC);
    endfunction

`ifdef PC_ALIGN_CHECK_EN
    assign redirect_bad = bus.redirect_target[1:0] != 2'b00;
`else
    assign redirect_bad = 1'b0;
`endif

    // Next-PC / next-state selection with trap > redirect > halt > fetch priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.trap_req) begin
                    pc_d = TRAP_VECTOR;
                end else if (bus.redirect_valid) begin
                    if (redirect_bad) err_d = 1'b1;
                    else              pc_d  = bus.redirect_target;
                end else if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.fetch_ready) begin
                    pc_d = pc_inc(pc_q);
                end
            end
            ST_HALT: begin
                if (bus.trap_req) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = ST_RUN;
                end else if (bus.redirect_valid) begin
                    if (redirect_bad) err_d = 1'b1;
                    else              pc_d  = bus.redirect_target;
                end else if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State, PC and error-pulse registers; reset forces the boot vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign bus.PC_Value       = pc_q;
    assign bus.fetch_valid    = (state_q == ST_RUN);
    assign bus.misaligned_err = err_q;

    logic [N-1:0]     ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d, ras_wptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ras_we;
    logic             ras_en;
    logic             ras_is_empty;
    logic             ras_is_full;

    assign ras_en       = (state_q != ST_BOOT);
    assign ras_is_empty = (cnt_q == '0);
    assign ras_is_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    // Stack pointer/count update; a push on a full stack overwrites the oldest
    // entry because the pointer simply wraps while the count saturates.
    always_comb begin
        ras_we   = 1'b0;
        ras_wptr = top_q;
        top_d    = top_q;
        cnt_d    = cnt_q;
        if (ras_en) begin
            if (bus.ras_push && (!bus.ras_pop || ras_is_empty)) begin
                ras_we   = 1'b1;
                ras_wptr = top_q + 1'b1;
                top_d    = top_q + 1'b1;
                if (!ras_is_full) cnt_d = cnt_q + 1'b1;
            end else if (bus.ras_push && bus.ras_pop) begin
                ras_we = 1'b1;
            end else if (bus.ras_pop && !ras_is_empty) begin
                top_d = top_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Stack control registers; entries themselves are hidden while count is 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage write port.
    always_ff @(posedge clk) begin
        if (ras_we) ras_mem[ras_wptr] <= bus.ras_push_addr;
    end

    assign bus.ras_top   = ras_is_empty ? '0 : ras_mem[top_q];
    assign bus.ras_empty = ras_is_empty;
    assign bus.ras_full  = ras_is_full;
endmodule

// File: tb/tb_pc_gen_unit.sv
`timescale 1ns/1ps
module tb_pc_gen_unit;
    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] TV = 32'h0040_0180;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [31:0] PC32  = ALIGN ? 32'h0000_0004 : 32'h0040_0102;
    localparam bit          ERR32 = ALIGN;

    logic clk = 1'b0;
    logic reset;

    pc_gen_unit_if #(.N(32)) bus ();

    pc_gen_unit #(
        .N(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INC(4), .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          fr, rv;
        logic [31:0] rt;
        bit          trap, halt, res, push;
        logic [31:0] pa;
        bit          pop;
        logic [31:0] e_pc;
        bit          e_fv;
        logic [31:0] e_top;
        bit          e_empty, e_full, e_err;
    } vec_t;

    function automatic vec_t vec(bit fr, bit rv, logic [31:0] rt, bit trap, bit halt,
                                 bit res, bit push, logic [31:0] pa, bit pop,
                                 logic [31:0] e_pc, bit e_fv, logic [31:0] e_top,
                                 bit e_empty, bit e_full, bit e_err);
        vec_t v;
        v.fr = fr; v.rv = rv; v.rt = rt; v.trap = trap; v.halt = halt; v.res = res;
        v.push = push; v.pa = pa; v.pop = pop; v.e_pc = e_pc; v.e_fv = e_fv;
        v.e_top = e_top; v.e_empty = e_empty; v.e_full = e_full; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(bit fr, bit rv, logic [31:0] rt, bit trap, bit halt, bit res,
                         bit push, logic [31:0] pa, bit pop);
        bus.fetch_ready     = fr;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.trap_req        = trap;
        bus.halt_req        = halt;
        bus.resume          = res;
        bus.ras_push        = push;
        bus.ras_push_addr   = pa;
        bus.ras_pop         = pop;
    endtask

    // Reference model: mode 0=boot 1=run 2=halt, stack kept as a bounded queue.
    logic [31:0] m_pc;
    int          m_mode;
    logic [31:0] m_q[$];
    bit          m_err;

    task automatic model_reset();
        m_pc = RV; m_mode = 0; m_q.delete(); m_err = 0;
    endtask

    task automatic model_step();
        m_err = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            if (bus.ras_push && bus.ras_pop && m_q.size() > 0) begin
                m_q[m_q.size()-1] = bus.ras_push_addr;
            end else if (bus.ras_push) begin
                m_q.push_back(bus.ras_push_addr);
                if (m_q.size() > 4) void'(m_q.pop_front());
            end else if (bus.ras_pop && m_q.size() > 0) begin
                void'(m_q.pop_back());
            end
            if (bus.trap_req) begin
                m_pc = TV; m_mode = 1;
            end else if (bus.redirect_valid) begin
                if (ALIGN && bus.redirect_target[1:0] != 2'b00) m_err = 1;
                else m_pc = bus.redirect_target;
            end else if (m_mode == 1) begin
                if (bus.halt_req) m_mode = 2;
                else if (bus.fetch_ready) m_pc = m_pc + 32'd4;
            end else if (bus.resume) begin
                m_mode = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},    bus.PC_Value, m_pc);
        chk({tag, ".fv"},    32'(bus.fetch_valid), 32'(m_mode == 1));
        chk({tag, ".top"},   bus.ras_top, (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'h0);
        chk({tag, ".empty"}, 32'(bus.ras_empty), 32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(bus.ras_full), 32'(m_q.size() == 4));
        chk({tag, ".err"},   32'(bus.misaligned_err), 32'(m_err));
    endtask

    vec_t tbl[34];

    initial begin
        // fr rv rt trap halt res push pa pop | pc fv top empty full err
        tbl[0]  = vec(1,0,0,0,0,0,1,32'h99,0, RV,           1,0,1,0,0);
        tbl[1]  = vec(1,0,0,0,0,0,0,0,0, 32'h0040_0004,     1,0,1,0,0);
        tbl[2]  = vec(1,0,0,0,0,0,0,0,0, 32'h0040_0008,     1,0,1,0,0);
        tbl[3]  = vec(0,0,0,0,0,0,0,0,0, 32'h0040_0008,     1,0,1,0,0);
        tbl[4]  = vec(0,0,0,0,0,0,0,0,0, 32'h0040_0008,     1,0,1,0,0);
        tbl[5]  = vec(0,0,0,0,0,0,0,0,0, 32'h0040_0008,     1,0,1,0,0);
        tbl[6]  = vec(1,1,32'h0040_0100,1,0,0,0,0,0, TV,    1,0,1,0,0);
        tbl[7]  = vec(0,1,32'h0040_0008,0,0,0,0,0,0, 32'h0040_0008, 1,0,1,0,0);
        tbl[8]  = vec(1,0,0,0,0,0,0,0,0, 32'h0040_000C,     1,0,1,0,0);
        tbl[9]  = vec(1,0,0,0,0,0,0,0,0, 32'h0040_0010,     1,0,1,0,0);
        tbl[10] = vec(1,0,0,0,1,0,0,0,0, 32'h0040_0010,     0,0,1,0,0);
        tbl[11] = vec(1,0,0,0,0,0,0,0,0, 32'h0040_0010,     0,0,1,0,0);
        tbl[12] = vec(0,1,32'h0040_0100,0,0,0,0,0,0, 32'h0040_0100, 0,0,1,0,0);
        tbl[13] = vec(0,0,0,0,1,0,0,0,0, 32'h0040_0100,     0,0,1,0,0);
        tbl[14] = vec(0,0,0,0,0,1,0,0,0, 32'h0040_0100,     1,0,1,0,0);
        tbl[15] = vec(1,0,0,0,0,0,0,0,0, 32'h0040_0104,     1,0,1,0,0);
        tbl[16] = vec(0,0,0,0,0,0,1,32'h10,0, 32'h0040_0104, 1,32'h10,0,0,0);
        tbl[17] = vec(0,0,0,0,0,0,1,32'h20,0, 32'h0040_0104, 1,32'h20,0,0,0);
        tbl[18] = vec(0,0,0,0,0,0,1,32'h30,0, 32'h0040_0104, 1,32'h30,0,0,0);
        tbl[19] = vec(0,0,0,0,0,0,1,32'h40,0, 32'h0040_0104, 1,32'h40,0,1,0);
        tbl[20] = vec(0,0,0,0,0,0,1,32'h50,0, 32'h0040_0104, 1,32'h50,0,1,0);
        tbl[21] = vec(0,0,0,0,0,0,0,0,1, 32'h0040_0104,     1,32'h40,0,0,0);
        tbl[22] = vec(0,0,0,0,0,0,0,0,1, 32'h0040_0104,     1,32'h30,0,0,0);
        tbl[23] = vec(0,0,0,0,0,0,0,0,1, 32'h0040_0104,     1,32'h20,0,0,0);
        tbl[24] = vec(0,0,0,0,0,0,0,0,1, 32'h0040_0104,     1,0,1,0,0);
        tbl[25] = vec(0,0,0,0,0,0,0,0,1, 32'h0040_0104,     1,0,1,0,0);
        tbl[26] = vec(0,0,0,0,0,0,1,32'h77,1, 32'h0040_0104, 1,32'h77,0,0,0);
        tbl[27] = vec(0,0,0,0,0,0,1,32'h88,1, 32'h0040_0104, 1,32'h88,0,0,0);
        tbl[28] = vec(0,0,0,0,0,0,0,0,1, 32'h0040_0104,     1,0,1,0,0);
        tbl[29] = vec(0,1,32'hFFFF_FFFC,0,0,0,0,0,0, 32'hFFFF_FFFC, 1,0,1,0,0);
        tbl[30] = vec(1,0,0,0,0,0,0,0,0, 32'h0000_0000,     1,0,1,0,0);
        tbl[31] = vec(1,0,0,0,0,0,0,0,0, 32'h0000_0004,     1,0,1,0,0);
        tbl[32] = vec(1,1,32'h0040_0102,0,0,0,0,0,0, PC32,  1,0,1,0,ERR32);
        tbl[33] = vec(0,0,0,0,0,0,0,0,0, PC32,              1,0,1,0,0);

        reset = 1'b0;
        drive(0,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc",    bus.PC_Value, RV);
        chk("rst.fv",    32'(bus.fetch_valid), 0);
        chk("rst.top",   bus.ras_top, 0);
        chk("rst.empty", 32'(bus.ras_empty), 1);
        chk("rst.full",  32'(bus.ras_full), 0);
        chk("rst.err",   32'(bus.misaligned_err), 0);
        reset = 1'b1;
        #2;
        chk("boot.fv", 32'(bus.fetch_valid), 0);
        chk("boot.pc", bus.PC_Value, RV);

        for (int i = 0; i < 34; i++) begin
            drive(tbl[i].fr, tbl[i].rv, tbl[i].rt, tbl[i].trap, tbl[i].halt,
                  tbl[i].res, tbl[i].push, tbl[i].pa, tbl[i].pop);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.pc", i),    bus.PC_Value, tbl[i].e_pc);
            chk($sformatf("tbl%0d.fv", i),    32'(bus.fetch_valid), 32'(tbl[i].e_fv));
            chk($sformatf("tbl%0d.top", i),   bus.ras_top, tbl[i].e_top);
            chk($sformatf("tbl%0d.empty", i), 32'(bus.ras_empty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d.full", i),  32'(bus.ras_full), 32'(tbl[i].e_full));
            chk($sformatf("tbl%0d.err", i),   32'(bus.misaligned_err), 32'(tbl[i].e_err));
        end

        // Populate the stack and leave RUN, then reset mid-cycle.
        drive(0,0,0,0,1,0,1,32'h1234,0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst.pc",    bus.PC_Value, RV);
        chk("mid_rst.fv",    32'(bus.fetch_valid), 0);
        chk("mid_rst.empty", 32'(bus.ras_empty), 1);
        chk("mid_rst.top",   bus.ras_top, 0);
        chk("mid_rst.err",   32'(bus.misaligned_err), 0);
        drive(1,0,0,0,0,0,0,0,0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rel%0d.pc", i), bus.PC_Value, RV + 32'(4 * i));
            chk($sformatf("rel%0d.fv", i), 32'(bus.fetch_valid), 1);
        end

        for (int c = 0; c < 800; c++) begin
            logic [31:0] tgt;
            case ($urandom % 4)
                0:       tgt = $urandom & 32'hFFFF_FFFC;
                1:       tgt = 32'hFFFF_FFF0 + (($urandom % 4) * 4);
                2:       tgt = $urandom | 32'h1;
                default: tgt = RV + (($urandom % 64) * 4);
            endcase
            drive(($urandom % 4) != 0, ($urandom % 8) == 0, tgt, ($urandom % 16) == 0,
                  ($urandom % 12) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                  $urandom, ($urandom % 3) == 0);
            if (($urandom % 150) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                check_model($sformatf("rnd_rst%0d", c));
                reset = 1'b1;
            end
            @(posedge clk);
            model_step();
            #1;
            check_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
